// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage: WIDTH-bit words in over valid/ready, one bit per clock out on x_out.
// Optional trailing even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             order_q;
    logic             at_last;
    logic             accept;
    logic             data_bit;

    assign at_last   = (state == SHIFT) && (bit_cnt == LAST);
    assign din_ready = !rst && ((state == IDLE) || at_last);
    assign accept    = din_valid && din_ready;
    assign data_bit  = order_q ? shreg[0] : shreg[WIDTH-1];

`ifdef PISO_PARITY_EN
    logic parity_q;

    // The parity bit follows the data bits in the slot after the last data bit.
    assign x_out = (state == SHIFT) && ((bit_cnt == LAST) ? parity_q : data_bit);
`else
    assign x_out = (state == SHIFT) && data_bit;
`endif

    assign x_valid    = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign frame_done = at_last;

    // An accept in the last bit slot reloads the word so the stream continues without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            order_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (accept) begin
            state   <= SHIFT;
            shreg   <= din;
            bit_cnt <= '0;
            order_q <= lsb_first;
`ifdef PISO_PARITY_EN
            parity_q <= ^din;
`endif
        end else if (state == SHIFT) begin
            if (bit_cnt == LAST) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= order_q ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: expected bits are queued at accept and popped as they appear.
module tb_piso_serializer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             lsb_first;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             frame_done;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t     expQ[$];
    int       errors = 0;
    int       checks = 0;
    logic [3:0] hist = 4'b0;
    int       histBits = 0;
    int       detCount = 0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .lsb_first  (lsb_first),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] w, input logic lsb);
        exp_t e;
        for (int i = 0; i < WIDTH; i++) begin
            e.b = lsb ? w[i] : w[WIDTH-1-i];
`ifdef PISO_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == WIDTH - 1);
`endif
            expQ.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.b    = ^w;
        e.last = 1'b1;
        expQ.push_back(e);
`endif
    endtask

    // Runs #1 after each rising edge: compares the displayed bit with the head of the scoreboard.
    task automatic checkOutput();
        exp_t e;
        logic expValid;
        expValid = (expQ.size() > 0);
        checkBit("x_valid", x_valid, expValid);
        checkBit("busy", busy, expValid);
        if (expValid) begin
            e = expQ.pop_front();
            checkBit("x_out", x_out, e.b);
            checkBit("frame_done", frame_done, e.last);
        end else begin
            checkBit("x_out_idle", x_out, 1'b0);
            checkBit("frame_done_idle", frame_done, 1'b0);
        end
        if (x_valid === 1'b1) begin
            hist = {hist[2:0], x_out};
            histBits++;
            if (histBits >= 4 && hist == 4'b1010) detCount++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Drives one cycle of inputs, checks din_ready against the model, then advances one edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] w,
                                 input logic lsb);
        logic expReady;
        rst       = r;
        din_valid = v;
        din       = w;
        lsb_first = lsb;
        #1;
        expReady = !r && (expQ.size() == 0);
        checkBit("din_ready", din_ready, expReady);
        if (r) expQ.delete();
        else if (v && expReady) pushWord(w, lsb);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; lsb_first = 1'b0;

        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);

        $display("[TB] single frame 8'hA5 MSB first");
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
        idle(10);

        $display("[TB] LSB first 8'hA5 and 8'h0D");
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
        idle(9);
        applyStimulus(1'b0, 1'b1, 8'h0D, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        idle(6);

        $display("[TB] back-to-back 8'hAA then 8'h55");
        hist = 4'b0; histBits = 0; detCount = 0;
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < WIDTH; i++) applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
        idle(WIDTH + 3);
`ifndef PISO_PARITY_EN
        checkInt("det1010_count", detCount, 5);
`endif

        $display("[TB] stall then accept");
        idle(5);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        idle(WIDTH + 2);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
        idle(4);
        applyStimulus(1'b0, 1'b1, 8'h81, 1'b1);
        idle(WIDTH + 2);

`ifdef PISO_PARITY_EN
        $display("[TB] parity frames 8'h07 and 8'h03");
        applyStimulus(1'b0, 1'b1, 8'h07, 1'b0);
        idle(WIDTH + 2);
        applyStimulus(1'b0, 1'b1, 8'h03, 1'b0);
        idle(WIDTH + 2);
`endif

        checkInt("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
